core_lsu: RTL
=============

# core_lsu

Load/store unit directly downstream of the integer ALU. It takes the effective address the ALU registers on RESULT (RS1 + IMM) together with the load/store opcode flags and the store data. It drives a single word-wide memory port with a req/ack handshake, and returns sign- or zero-extended load data. Misaligned accesses and memory timeouts are detected without waiting on memory.

## Interface
- TIMEOUT, default 255: cycles MEM_REQ may stay high without MEM_ACK before the access is abandoned (1..65535).
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; ADDR, WDATA and opcode flags are valid this cycle.
- I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW, I_FLW, I_FSW  in  1 each  opcode flags; exactly one set with START.
- ADDR  in  32  byte address (ALU RESULT).
- WDATA  in  32  store data (RS2 or FP source).
- BUSY  out  1  access in flight; START ignored while high.
- DONE  out  1  one-cycle completion pulse (success, misalign or fault).
- MISALIGN  out  1  pulses with DONE for misaligned access.
- FAULT  out  1  pulses with DONE on timeout.
- RDATA  out  32  extended load result; valid from DONE until next load DONE.
- MEM_REQ  out  1  request, held until MEM_ACK.
- MEM_WE  out  1  1 = write.
- MEM_ADDR  out  32  {ADDR[31:2], 2'b00}.
- MEM_BE  out  4  byte enables.
- MEM_WDATA  out  32  lane-replicated store data.
- MEM_ACK  in  1  accept/complete; for reads MEM_RDATA valid same cycle.
- MEM_RDATA  in  32  read word.

## Operation
- States: IDLE, REQ, RESP.
- IDLE:
  - START with no flag set: ignored.
  - START with any flag: latch ADDR, WDATA, op, lane = ADDR[1:0].
  - Misaligned (H ops with ADDR[0]=1; W/FLW/FSW with ADDR[1:0]≠0): go to RESP with MISALIGN; no memory request.
  - Otherwise: go to REQ.
- REQ:
  - MEM_REQ=1 with MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA registered and stable until ack.
  - MEM_ACK: capture MEM_RDATA (loads), go to RESP.
  - Counter reaches TIMEOUT without ack: drop MEM_REQ, go to RESP with FAULT.
- RESP: DONE=1 (plus MISALIGN/FAULT if flagged), update RDATA for successful loads only; next state IDLE.
- BUSY = state ≠ IDLE.
- Byte enables:
  - Byte ops: 4'b0001 << lane.
  - Half ops: 4'b0011 << lane.
  - Word/FP ops: 4'b1111.
- Store data:
  - SB: {4{WDATA[7:0]}}.
  - SH: {2{WDATA[15:0]}}.
  - SW/FSW: WDATA.
- Load extraction from the captured word:
  - LB: byte[lane] sign-extended; LBU: zero-extended.
  - LH: half[lane[1]] sign-extended; LHU: zero-extended.
  - LW/FLW: full word.
- RDATA is unchanged by stores, misaligned loads and faults.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, and all outputs 0, including RDATA, MEM_* and BUSY.
- Reset mid-access drops MEM_REQ immediately; an ack arriving during reset is ignored.
- Zero-wait memory: START at cycle t → MEM_REQ high t+1 → MEM_ACK at t+1 → DONE t+2 → next START accepted at t+3 (the cycle DONE is high is still BUSY).
- With w wait cycles, DONE arrives at t+2+w.
- Misaligned access: DONE+MISALIGN at t+1, MEM_REQ never asserted.
- Timeout: MEM_REQ is high for exactly TIMEOUT cycles (t+1..t+TIMEOUT), low at t+TIMEOUT+1 with DONE+FAULT. An ack in the same cycle the count expires counts as success.
- MEM_ACK while MEM_REQ is low is ignored.
- START while BUSY is ignored; it is not queued.

## Test plan
- LB at ADDR 0x1003, MEM_RDATA 0x80112233, zero-wait ack → MEM_ADDR 0x1000, MEM_BE 4'b1000, DONE at t+2, RDATA 0xFFFFFF80. Same with LBU → 0x00000080.
- SH at ADDR 0x2002, WDATA 0xDEADBEEF → MEM_WE 1, MEM_BE 4'b1100, MEM_WDATA 0xBEEFBEEF. RDATA unchanged.
- LW at ADDR 0x3001 → DONE+MISALIGN at t+1, MEM_REQ never high. LH at 0x3002 proceeds normally.
- TIMEOUT=4, SW with no ack → MEM_REQ high 4 cycles, then DONE+FAULT. A subsequent START is accepted.
- LHU at 0x4002, ack after 3 wait cycles with MEM_RDATA 0xF00D1234 → DONE at t+5, RDATA 0x0000F00D. START pulsed at t+2 is ignored.
- RST asserted while MEM_REQ high → MEM_REQ, BUSY, RDATA 0 immediately. After release, an LW to 0x0 completes normally.

Source files
------------

// File: rtl/core_lsu_if.sv
// Word-wide memory port with req/ack handshake between the LSU (master)
// and the memory system (slave).
interface core_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: one access at a time on a word-wide req/ack memory port,
// with early misalignment rejection, request timeout and load extension.
module core_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              lb_i,
    input  logic              lh_i,
    input  logic              lw_i,
    input  logic              lbu_i,
    input  logic              lhu_i,
    input  logic              sb_i,
    input  logic              sh_i,
    input  logic              sw_i,
    input  logic              flw_i,
    input  logic              fsw_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              fault_o,
    output logic [31:0]       rdata_o,
    core_lsu_if.master        mem
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  lane_q, lane_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic        fault_q, fault_d;

    logic        any_op, is_b, is_h, is_st, is_sgn, is_mis;
    logic [1:0]  size_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] ln);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_B:    extract = {{24{sg & b[7]}}, b};
            SZ_H:    extract = {{16{sg & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    assign any_op  = |{lb_i, lh_i, lw_i, lbu_i, lhu_i, sb_i, sh_i, sw_i, flw_i, fsw_i};
    assign is_b    = lb_i | lbu_i | sb_i;
    assign is_h    = lh_i | lhu_i | sh_i;
    assign is_st   = sb_i | sh_i | sw_i | fsw_i;
    assign is_sgn  = lb_i | lh_i;
    assign size_in = is_b ? SZ_B : (is_h ? SZ_H : SZ_W);
    assign is_mis  = is_h ? addr_i[0] : (!is_b && (addr_i[1:0] != 2'b00));

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = wdata_i;
        case (size_in)
            SZ_B: begin
                be_in    = 4'b0001 << addr_i[1:0];
                wdata_in = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_in    = 4'b0011 << addr_i[1:0];
                wdata_in = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        sign_d     = sign_q;
        lane_d     = lane_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        fault_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && any_op) begin
                    size_d = size_in;
                    sign_d = is_sgn;
                    lane_d = addr_i[1:0];
                    if (is_mis) begin
                        state_d    = S_RESP;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        we_d    = is_st;
                        addr_d  = {addr_i[31:2], 2'b00};
                        be_d    = be_in;
                        wdata_d = wdata_in;
                        cnt_d   = 16'd0;
                    end
                end
            end
            S_REQ: begin
                // An ack in the expiry cycle wins over the timeout.
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    if (!we_q) rdata_d = extract(mem.mem_rdata, size_q, sign_q, lane_q);
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            size_q     <= SZ_B;
            sign_q     <= 1'b0;
            lane_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            lane_q     <= lane_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign misalign_o    = misalign_q;
    assign fault_o       = fault_q;
    assign rdata_o       = rdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule
